// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the picorv32 boot-load controller.
package riscv_loader_pkg;
  localparam int ADDR_BITS      = 24;
  localparam int LEN_BITS       = 24;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [7:0] MAGIC  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_RUN  = 3'd4
  } state_t;

  function automatic logic is_magic(input logic [7:0] tag, input logic [7:0] magic);
    return (tag == magic);
  endfunction
endpackage

// File: rtl/riscv_loader_ctrl_serializer.sv
// Word-to-byte serializer: loads a word plus valid-byte count and emits one
// byte per cycle, low byte first, from registered outputs.
module word2byte_serializer #(
  parameter int W     = 32,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [W-1:0]     word,
  input  logic [CNT_W-1:0] nbytes,
  output logic [7:0]       byte_data,
  output logic             valid,
  output logic             last,
  output logic             empty,
  output logic             free_next
);
  logic [W-1:0]     word_r;
  logic [W-1:0]     word_nxt_s;
  logic [CNT_W-1:0] rem_r;
  logic [CNT_W-1:0] rem_nxt_s;
  logic             valid_r;
  logic             last_r;
  logic             empty_r;

  // Next shift-register contents and remaining-byte count
  always_comb begin
    word_nxt_s = word_r;
    rem_nxt_s  = rem_r;
    if (load) begin
      word_nxt_s = word;
      rem_nxt_s  = nbytes;
    end else if (rem_r != CNT_W'(0)) begin
      word_nxt_s = word_r >> 8;
      rem_nxt_s  = rem_r - CNT_W'(1);
    end else begin
      word_nxt_s = word_r;
      rem_nxt_s  = rem_r;
    end
  end

  // Serializer state and its registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_r  <= '0;
      rem_r   <= CNT_W'(0);
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      word_r  <= word_nxt_s;
      rem_r   <= rem_nxt_s;
      valid_r <= (rem_nxt_s != CNT_W'(0));
      last_r  <= (rem_nxt_s == CNT_W'(1));
      empty_r <= (rem_nxt_s == CNT_W'(0));
    end
  end

  // Free next cycle means empty or on the final byte, so a new word can follow gaplessly
  assign free_next = (rem_nxt_s <= CNT_W'(1));
  assign byte_data = word_r[7:0];
  assign valid     = valid_r;
  assign last      = last_r;
  assign empty     = empty_r;
endmodule

// File: rtl/riscv_loader_ctrl.sv
// Boot-load controller: unpacks a header/base/data word stream into byte writes
// on the picorv32 instruction-config port and gates the core reset.
module riscv_loader_ctrl #(
  parameter int         PAYLOAD_BITS = 32,
  parameter int         ADDR_BITS    = 24,
  parameter logic [7:0] MAGIC        = 8'hA5
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic                    ap_start,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    val_in,
  output logic                    ready_upward,
  output logic [ADDR_BITS-1:0]    instr_config_addr,
  output logic [7:0]              instr_config_din,
  output logic                    instr_config_wr_en,
  output logic                    core_resetn,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  import riscv_loader_pkg::*;

  localparam int LW    = LEN_BITS;
  localparam int BPW   = PAYLOAD_BITS / 8;
  localparam int CNT_W = $clog2(BPW + 1);

  state_t             state_r, state_nxt_s;
  logic [LW-1:0]      len_rem_r, len_nxt_s;
  logic [ADDR_BITS-1:0] addr_r;
  logic               ready_r, busy_r, done_r, core_resetn_r, err_r;
  logic               acc_s, hdr_ok_s, load_s, err_nxt_s;
  logic [CNT_W-1:0]   nbytes_s;
  logic               ser_valid_s, ser_last_s, ser_empty_s, ser_free_s;

  assign acc_s    = val_in & ready_r;
  assign hdr_ok_s = is_magic(din[PAYLOAD_BITS-1 -: 8], MAGIC);
  assign load_s   = acc_s & (state_r == ST_DATA);
  assign nbytes_s = (len_rem_r >= LW'(BPW)) ? CNT_W'(BPW) : len_rem_r[CNT_W-1:0];

  word2byte_serializer #(.W(PAYLOAD_BITS), .CNT_W(CNT_W)) u_ser (
    .clk       (clk_user),
    .reset     (reset),
    .load      (load_s),
    .word      (din),
    .nbytes    (nbytes_s),
    .byte_data (instr_config_din),
    .valid     (ser_valid_s),
    .last      (ser_last_s),
    .empty     (ser_empty_s),
    .free_next (ser_free_s)
  );

  // Next state, remaining byte count and header error decode
  always_comb begin
    state_nxt_s = state_r;
    len_nxt_s   = len_rem_r;
    err_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (acc_s && hdr_ok_s) begin
          state_nxt_s = ST_ADDR;
          len_nxt_s   = din[LW-1:0];
        end else begin
          err_nxt_s = acc_s;
        end
      end
      ST_ADDR: begin
        if (acc_s) begin
          state_nxt_s = (len_rem_r == LW'(0)) ? ST_DONE : ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (load_s) begin
          len_nxt_s = len_rem_r - LW'(nbytes_s);
        end else if (ser_valid_s && ser_last_s && (len_rem_r == LW'(0))) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_DONE, ST_RUN: begin
        // A new header in DONE/RUN starts a reload and pulls the core back into reset
        if (acc_s && hdr_ok_s) begin
          state_nxt_s = ST_ADDR;
          len_nxt_s   = din[LW-1:0];
        end else if (state_r == ST_DONE) begin
          err_nxt_s   = acc_s;
          state_nxt_s = ap_start ? ST_RUN : ST_DONE;
        end else begin
          err_nxt_s   = acc_s;
          state_nxt_s = ap_start ? ST_RUN : ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      len_rem_r     <= LW'(0);
      addr_r        <= ADDR_BITS'(0);
      ready_r       <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      core_resetn_r <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      len_rem_r <= len_nxt_s;
      if (acc_s && (state_r == ST_ADDR)) begin
        addr_r <= din[ADDR_BITS-1:0];
      end else if (!ser_empty_s) begin
        addr_r <= addr_r + ADDR_BITS'(1);
      end else begin
        addr_r <= addr_r;
      end
      ready_r       <= (state_nxt_s != ST_DATA) || (ser_free_s && (len_nxt_s != LW'(0)));
      busy_r        <= (state_nxt_s == ST_ADDR) || (state_nxt_s == ST_DATA);
      done_r        <= (state_nxt_s == ST_DONE) || (state_nxt_s == ST_RUN);
      core_resetn_r <= (state_nxt_s == ST_RUN);
      err_r         <= err_nxt_s;
    end
  end

  assign ready_upward       = ready_r;
  assign instr_config_addr  = addr_r;
  assign instr_config_wr_en = ser_valid_s;
  assign core_resetn        = core_resetn_r;
  assign busy               = busy_r;
  assign done               = done_r;
  assign err                = err_r;
endmodule
